// File: rtl/elink_frame_rx.sv
// E-link uplink frame receiver: hunts a 2-bit/clock stream for the start-of-frame
// word, deserialises the payload, checks the trailing CRC-8 and counts frames/errors.
module elink_frame_rx #(
    parameter logic [15:0] SOF       = 16'hE5A7,
    parameter int          PAYLOAD_W = 76
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_en,
    input  logic [1:0]           rx_elink2bit,
    output logic [PAYLOAD_W-1:0] data_out,
    output logic                 data_valid,
    output logic                 crc_err,
    output logic                 busy,
    output logic [15:0]          frame_cnt,
    output logic [7:0]           err_cnt
);

    localparam int CNT_W = $clog2(PAYLOAD_W / 2);
    localparam logic [CNT_W-1:0] LAST_PAY_SYM = CNT_W'(PAYLOAD_W / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CRC_SYM = CNT_W'(3);

    typedef enum logic [1:0] {ST_HUNT, ST_PAYLOAD, ST_CRC} state_t;

    state_t                 state_reg, state_next;
    logic [13:0]            hist_reg;
    logic [CNT_W-1:0]       sym_cnt_reg;
    logic [7:0]             crc_reg;
    logic [5:0]             rx_crc_reg;
    logic [PAYLOAD_W-1:0]   payload_reg;
    logic [PAYLOAD_W-1:0]   data_out_reg;
    logic                   data_valid_reg;
    logic                   crc_err_reg;
    logic [15:0]            frame_cnt_reg;
    logic [7:0]             err_cnt_reg;

    logic                   sof_match;
    logic [7:0]             crc_next;
    logic [7:0]             rx_crc_full;

    // One serial CRC-8 (poly 0x07) step per received bit.
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    assign sof_match   = ({hist_reg, rx_elink2bit} == SOF);
    assign crc_next    = crc_step(crc_step(crc_reg, rx_elink2bit[1]), rx_elink2bit[0]);
    assign rx_crc_full = {rx_crc_reg, rx_elink2bit};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_HUNT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (!rx_en) begin
            state_next = ST_HUNT;
        end else begin
            case (state_reg)
                ST_HUNT:    if (sof_match) state_next = ST_PAYLOAD;
                ST_PAYLOAD: if (sym_cnt_reg == LAST_PAY_SYM) state_next = ST_CRC;
                ST_CRC:     if (sym_cnt_reg == LAST_CRC_SYM) state_next = ST_HUNT;
                default:    state_next = ST_HUNT;
            endcase
        end
    end

    always_comb begin
        busy = (state_reg == ST_PAYLOAD) || (state_reg == ST_CRC);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hist_reg       <= '0;
            sym_cnt_reg    <= '0;
            crc_reg        <= '0;
            rx_crc_reg     <= '0;
            payload_reg    <= '0;
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            crc_err_reg    <= 1'b0;
            frame_cnt_reg  <= '0;
            err_cnt_reg    <= '0;
        end else begin
            data_valid_reg <= 1'b0;
            crc_err_reg    <= 1'b0;
            if (!rx_en) begin
                hist_reg    <= '0;
                sym_cnt_reg <= '0;
            end else begin
                case (state_reg)
                    ST_HUNT: begin
                        // History is zeroed on exit so frame contents never alias SOF.
                        if (sof_match) begin
                            hist_reg    <= '0;
                            sym_cnt_reg <= '0;
                            crc_reg     <= '0;
                        end else begin
                            hist_reg <= {hist_reg[11:0], rx_elink2bit};
                        end
                    end
                    ST_PAYLOAD: begin
                        payload_reg <= {payload_reg[PAYLOAD_W-3:0], rx_elink2bit};
                        crc_reg     <= crc_next;
                        sym_cnt_reg <= (sym_cnt_reg == LAST_PAY_SYM) ? '0 : sym_cnt_reg + 1'b1;
                    end
                    ST_CRC: begin
                        rx_crc_reg  <= rx_crc_full[5:0];
                        sym_cnt_reg <= sym_cnt_reg + 1'b1;
                        if (sym_cnt_reg == LAST_CRC_SYM) begin
                            if (rx_crc_full == crc_reg) begin
                                data_out_reg   <= payload_reg;
                                data_valid_reg <= 1'b1;
                                frame_cnt_reg  <= frame_cnt_reg + 16'd1;
                            end else begin
                                crc_err_reg <= 1'b1;
                                if (err_cnt_reg != 8'hFF) begin
                                    err_cnt_reg <= err_cnt_reg + 8'd1;
                                end
                            end
                        end
                    end
                    default: begin
                        hist_reg <= '0;
                    end
                endcase
            end
        end
    end

    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign crc_err    = crc_err_reg;
    assign frame_cnt  = frame_cnt_reg;
    assign err_cnt    = err_cnt_reg;

endmodule

// File: tb/tb_elink_frame_rx.sv
// Directed bench for elink_frame_rx: reset/idle, good frames, back-to-back,
// CRC errors with counter saturation, rx_en abort and mid-frame reset.
module tb_elink_frame_rx;

    logic        clk;
    logic        rst;
    logic        rx_en;
    logic [1:0]  rx_elink2bit;
    logic [75:0] data_out;
    logic        data_valid;
    logic        crc_err;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    int vectors     = 0;
    int miscompares = 0;

    int          cyc = 0;
    int          dv_count = 0;
    int          ce_count = 0;
    int          both_high = 0;
    int          dout_glitch = 0;
    logic        rst_last = 1'b0;
    logic [75:0] prev_dout = '0;
    int          dv_cyc_q[$];
    logic [75:0] dv_dout_q[$];
    logic [15:0] dv_fcnt_q[$];

    elink_frame_rx dut (
        .clk          (clk),
        .rst          (rst),
        .rx_en        (rx_en),
        .rx_elink2bit (rx_elink2bit),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .crc_err      (crc_err),
        .busy         (busy),
        .frame_cnt    (frame_cnt),
        .err_cnt      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_last <= rst;
    end

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            dv_count <= dv_count + 1;
            dv_cyc_q.push_back(cyc);
            dv_dout_q.push_back(data_out);
            dv_fcnt_q.push_back(frame_cnt);
        end
        if (crc_err === 1'b1) ce_count <= ce_count + 1;
        if (data_valid === 1'b1 && crc_err === 1'b1) both_high <= both_high + 1;
        if (data_out !== prev_dout && data_valid !== 1'b1 && rst_last === 1'b1)
            dout_glitch <= dout_glitch + 1;
        prev_dout <= data_out;
    end

    task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] crc8_ref(input logic [75:0] p);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 75; i >= 0; i--) begin
            fb = c[7] ^ p[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    task automatic drive(input logic [1:0] s);
        @(negedge clk);
        rx_elink2bit = s;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(2'b00);
    endtask

    task automatic send_sof();
        logic [15:0] w;
        w = 16'hE5A7;
        for (int i = 0; i < 8; i++) drive(w[15-2*i -: 2]);
    endtask

    task automatic send_payload(input logic [75:0] p, input int n);
        for (int i = 0; i < n; i++) drive(p[75-2*i -: 2]);
    endtask

    task automatic send_crc(input logic [7:0] c, input int n);
        for (int i = 0; i < n; i++) drive(c[7-2*i -: 2]);
    endtask

    task automatic send_frame(input logic [75:0] p, input logic [7:0] c);
        send_sof();
        send_payload(p, 38);
        send_crc(c, 4);
    endtask

    localparam logic [75:0] P_ABORT = 76'hA_BCDE_F012_3456_789A;

    initial begin
        rst          = 1'b0;
        rx_en        = 1'b0;
        rx_elink2bit = 2'b00;

        // Reset with random line activity
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rx_elink2bit = 2'($urandom_range(0, 3));
            rx_en        = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk("rst_data_valid", 76'(data_valid), 76'd0);
        chk("rst_crc_err",    76'(crc_err),    76'd0);
        chk("rst_busy",       76'(busy),       76'd0);
        chk("rst_frame_cnt",  76'(frame_cnt),  76'd0);
        chk("rst_err_cnt",    76'(err_cnt),    76'd0);
        chk("rst_data_out",   data_out,        76'd0);
        rst          = 1'b1;
        rx_en        = 1'b1;
        rx_elink2bit = 2'b00;

        idle(100);
        chk("idle_busy",      76'(busy),      76'd0);
        chk("idle_frame_cnt", 76'(frame_cnt), 76'd0);
        chk("idle_err_cnt",   76'(err_cnt),   76'd0);
        chk("idle_data_out",  data_out,       76'd0);
        chk("idle_dv_count",  76'(dv_count),  76'd0);
        chk("idle_ce_count",  76'(ce_count),  76'd0);

        // Zero-payload frame followed back-to-back by unit payload frame
        send_frame(76'h0, 8'h00);
        send_frame(76'h1, 8'h07);
        idle(1);
        chk("b2b_data_valid", 76'(data_valid), 76'd1);
        chk("b2b_data_out",   data_out,        76'h1);
        chk("b2b_frame_cnt",  76'(frame_cnt),  76'd2);
        chk("b2b_busy",       76'(busy),       76'd0);
        chk("b2b_crc_err",    76'(crc_err),    76'd0);
        idle(1);
        chk("b2b_pulse_width", 76'(data_valid), 76'd0);
        chk("b2b_dv_count",    76'(dv_count),   76'd2);
        chk("b2b_ce_count",    76'(ce_count),   76'd0);
        if (dv_cyc_q.size() == 2) begin
            chk("zero_data_out",  dv_dout_q[0],            76'h0);
            chk("zero_frame_cnt", 76'(dv_fcnt_q[0]),       76'd1);
            chk("b2b_spacing",    76'(dv_cyc_q[1] - dv_cyc_q[0]), 76'd50);
        end else begin
            chk("b2b_pulse_queue", 76'(dv_cyc_q.size()), 76'd2);
        end

        // Single bad CRC
        send_frame(76'h0, 8'h01);
        idle(1);
        chk("bad_crc_err",    76'(crc_err),    76'd1);
        chk("bad_data_valid", 76'(data_valid), 76'd0);
        chk("bad_err_cnt",    76'(err_cnt),    76'd1);
        chk("bad_data_out",   data_out,        76'h1);
        chk("bad_frame_cnt",  76'(frame_cnt),  76'd2);
        idle(1);
        chk("bad_pulse_width", 76'(crc_err), 76'd0);

        // Saturate the error counter
        for (int i = 0; i < 300; i++) send_frame(76'h0, 8'h01);
        idle(2);
        chk("sat_err_cnt",   76'(err_cnt),   76'hFF);
        chk("sat_ce_count",  76'(ce_count),  76'd301);
        chk("sat_frame_cnt", 76'(frame_cnt), 76'd2);
        chk("sat_dv_count",  76'(dv_count),  76'd2);
        chk("sat_data_out",  data_out,       76'h1);

        // Abort via rx_en after payload symbol 20
        send_sof();
        send_payload(76'hF_FFFF_0000_FFFF_0000, 20);
        chk("abort_busy_mid", 76'(busy), 76'd1);
        @(negedge clk);
        rx_en        = 1'b0;
        rx_elink2bit = 2'b11;
        @(negedge clk);
        chk("abort_busy_off", 76'(busy), 76'd0);
        send_payload(76'hF_FFFF_0000_FFFF_0000, 10);
        @(negedge clk);
        rx_en        = 1'b1;
        rx_elink2bit = 2'b00;
        idle(3);
        chk("abort_dv_count", 76'(dv_count), 76'd2);
        chk("abort_ce_count", 76'(ce_count), 76'd301);
        send_frame(P_ABORT, crc8_ref(P_ABORT));
        idle(1);
        chk("abort_data_valid", 76'(data_valid), 76'd1);
        chk("abort_data_out",   data_out,        P_ABORT);
        chk("abort_frame_cnt",  76'(frame_cnt),  76'd3);

        // Reset at CRC symbol 2 of a good frame
        idle(2);
        send_sof();
        send_payload(76'h1, 38);
        send_crc(8'h07, 2);
        @(negedge clk);
        rst          = 1'b0;
        rx_elink2bit = 2'b11;
        @(negedge clk);
        rst          = 1'b1;
        rx_elink2bit = 2'b00;
        chk("mrst_frame_cnt",  76'(frame_cnt),  76'd0);
        chk("mrst_err_cnt",    76'(err_cnt),    76'd0);
        chk("mrst_data_out",   data_out,        76'd0);
        chk("mrst_busy",       76'(busy),       76'd0);
        chk("mrst_data_valid", 76'(data_valid), 76'd0);
        idle(5);
        chk("mrst_dv_count", 76'(dv_count), 76'd3);
        chk("mrst_ce_count", 76'(ce_count), 76'd301);
        send_frame(76'h1, 8'h07);
        idle(1);
        chk("mrst_next_valid",     76'(data_valid), 76'd1);
        chk("mrst_next_frame_cnt", 76'(frame_cnt),  76'd1);
        chk("mrst_next_data_out",  data_out,        76'h1);
        idle(2);

        chk("never_both_pulses",  76'(both_high),   76'd0);
        chk("dout_only_on_valid", 76'(dout_glitch), 76'd0);
        chk("final_dv_count",     76'(dv_count),    76'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
